// File: rtl/motor_cmd_spi_rx.sv
// rtl/motor_cmd_spi_rx.sv - SPI-slave motor command receiver with checksum and link watchdog
module motor_cmd_spi_rx #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  CHK_SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       motor1_sign,
    output logic [6:0] motor1_count,
    output logic       motor2_sign,
    output logic [6:0] motor2_count,
    output logic       link_ok,
    output logic       frame_ok,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t      state, state_nx;
    logic [2:0]  sck_sync, cs_sync;
    logic [1:0]  mosi_sync;
    logic [23:0] shreg;
    logic [4:0]  bit_cnt;
    logic [15:0] wd_cnt;

    logic sck_rise, cs_rise, cs_fall, mosi_s;
    logic clear, shift_en, len_err, accept, chk_err, timeout_hit;

    // bit 0 = stage 1, bit 1 = stage 2, bit 2 = edge-detect delay
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign cs_rise  = cs_sync[1] & ~cs_sync[2];
    assign cs_fall  = ~cs_sync[1] & cs_sync[2];
    assign mosi_s   = mosi_sync[1];

    assign accept  = (state == CHECK) &&
                     (shreg[7:0] == (shreg[23:16] ^ shreg[15:8] ^ CHK_SEED));
    assign chk_err = (state == CHECK) && !accept;
    assign timeout_hit = (wd_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            state     <= IDLE;
        end else begin
            sck_sync  <= {sck_sync[1:0], sck};
            cs_sync   <= {cs_sync[1:0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
            state     <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        shift_en = 1'b0;
        len_err  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nx = SHIFT;
                    clear    = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nx = (bit_cnt == 5'd24) ? CHECK : IDLE;
                    len_err  = (bit_cnt != 5'd24);
                end else if (sck_rise) begin
                    shift_en = 1'b1;
                end
            end
            CHECK: begin
                // back-to-back frame: a new select can start while the checksum is judged
                if (cs_fall) begin
                    state_nx = SHIFT;
                    clear    = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= {shreg[22:0], mosi_s};
            bit_cnt <= (bit_cnt == 5'd25) ? 5'd25 : bit_cnt + 5'd1;
        end
    end

    // accept takes priority over a coincident timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt       <= '0;
            motor1_sign  <= 1'b0;
            motor1_count <= '0;
            motor2_sign  <= 1'b0;
            motor2_count <= '0;
            link_ok      <= 1'b0;
            frame_ok     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_ok  <= accept;
            frame_err <= len_err | chk_err;
            if (accept) begin
                wd_cnt       <= '0;
                motor1_sign  <= shreg[23];
                motor1_count <= shreg[22:16];
                motor2_sign  <= shreg[15];
                motor2_count <= shreg[14:8];
                link_ok      <= 1'b1;
            end else begin
                if (wd_cnt != TIMEOUT_CYCLES)
                    wd_cnt <= wd_cnt + 16'd1;
                if (timeout_hit) begin
                    motor1_sign  <= 1'b0;
                    motor1_count <= '0;
                    motor2_sign  <= 1'b0;
                    motor2_count <= '0;
                    link_ok      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_cmd_spi_rx.sv
// tb/tb_motor_cmd_spi_rx.sv - table-driven bench for motor_cmd_spi_rx
module tb_motor_cmd_spi_rx;

    logic clk = 1'b0;
    logic reset, sck, cs_n, mosi;
    logic m1s, m2s, lnk, fok, ferr;
    logic [6:0] m1c, m2c;
    logic w_m1s, w_m2s, w_lnk, w_fok, w_ferr;
    logic [6:0] w_m1c, w_m2c;
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    motor_cmd_spi_rx dut (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .motor1_sign(m1s), .motor1_count(m1c), .motor2_sign(m2s), .motor2_count(m2c),
        .link_ok(lnk), .frame_ok(fok), .frame_err(ferr)
    );

    motor_cmd_spi_rx #(.TIMEOUT_CYCLES(16'd100)) dut_wd (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .motor1_sign(w_m1s), .motor1_count(w_m1c), .motor2_sign(w_m2s), .motor2_count(w_m2c),
        .link_ok(w_lnk), .frame_ok(w_fok), .frame_err(w_ferr)
    );

    wire [15:0] outs   = {m1s, m1c, m2s, m2c};
    wire [15:0] w_outs = {w_m1s, w_m1c, w_m2s, w_m2c};

    typedef struct {
        logic [24:0] bits;
        int          n;
        int          ok_k;
        int          err_k;
        logic [15:0] outs;
        logic        link;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic shift_bits(input logic [24:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            repeat (half) @(negedge clk);
            sck = 1'b1;
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // raise cs_n and record at which edge after t0 each pulse appears (-1 none, 99 repeated)
    task automatic finish_frame(output int ok_at, output int err_at, output int acc);
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        acc = cyc + 4;
        ok_at = -1;
        err_at = -1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (fok)  ok_at  = (ok_at  < 0) ? k : 99;
            if (ferr) err_at = (err_at < 0) ? k : 99;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [24:0] bits, input int n,
                              output int ok_at, output int err_at, output int acc);
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        shift_bits(bits, n, 3);
        finish_frame(ok_at, err_at, acc);
    endtask

    initial begin
        int ok_at, err_at, acc, a1;

        vecs[0] = '{25'h09E645F, 24,  3, -1, 16'h9E64, 1'b1};
        vecs[1] = '{25'h09E645E, 24, -1,  3, 16'h9E64, 1'b1};
        vecs[2] = '{25'h04F322F, 23, -1,  2, 16'h9E64, 1'b1};
        vecs[3] = '{25'h19E645F, 25, -1,  2, 16'h9E64, 1'b1};
        vecs[4] = '{25'h0058020, 24,  3, -1, 16'h0580, 1'b1};
        vecs[5] = '{25'h00000A5, 24,  3, -1, 16'h0000, 1'b1};
        vecs[6] = '{25'h07F7FA5, 24,  3, -1, 16'h7F7F, 1'b1};

        reset = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs, 16'h0);
        chk("reset_link", lnk, 1'b0);
        chk("reset_frame_ok", fok, 1'b0);
        chk("reset_frame_err", ferr, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].bits, vecs[v].n, ok_at, err_at, acc);
            chk($sformatf("v%0d_ok_at", v), ok_at, vecs[v].ok_k);
            chk($sformatf("v%0d_err_at", v), err_at, vecs[v].err_k);
            chk($sformatf("v%0d_outs", v), outs, vecs[v].outs);
            chk($sformatf("v%0d_link", v), lnk, vecs[v].link);
        end

        // watchdog expiry exactly TIMEOUT cycles after the accepting edge
        send_frame(25'h09E645F, 24, ok_at, err_at, acc);
        while (cyc < acc + 99) @(negedge clk);
        chk("wd_before_link", w_lnk, 1'b1);
        chk("wd_before_outs", w_outs, 16'h9E64);
        @(negedge clk);
        chk("wd_expired_link", w_lnk, 1'b0);
        chk("wd_expired_outs", w_outs, 16'h0);
        chk("long_timeout_holds", outs, 16'h9E64);
        send_frame(25'h0058020, 24, ok_at, err_at, acc);
        chk("wd_restore_link", w_lnk, 1'b1);
        chk("wd_restore_outs", w_outs, 16'h0580);

        // second frame accepted in the very cycle the watchdog would fire
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        shift_bits(25'h09E645F, 24, 3);
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        a1 = cyc + 4;
        repeat (2) @(negedge clk);
        cs_n = 1'b0;
        shift_bits(25'h0058020, 24, 2);
        while (cyc < a1 + 96) @(negedge clk);
        cs_n = 1'b1;
        while (cyc < a1 + 99) @(negedge clk);
        chk("align_pre_link", w_lnk, 1'b1);
        chk("align_pre_outs", w_outs, 16'h9E64);
        @(negedge clk);
        chk("align_frame_ok", w_fok, 1'b1);
        chk("align_link", w_lnk, 1'b1);
        chk("align_outs", w_outs, 16'h0580);
        while (cyc < a1 + 199) @(negedge clk);
        chk("align_restart_link", w_lnk, 1'b1);
        @(negedge clk);
        chk("align_restart_expire", w_lnk, 1'b0);
        chk("align_restart_outs", w_outs, 16'h0);

        // asynchronous reset at bit 12 of a frame
        chk("pre_reset_outs", outs, 16'h0580);
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        shift_bits(25'h00009E6, 12, 3);
        #2 reset = 1'b0;
        #1;
        chk("midreset_outs", outs, 16'h0);
        chk("midreset_link", lnk, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        shift_bits(25'h000045F, 12, 3);
        finish_frame(ok_at, err_at, acc);
        chk("midreset_tail_ok", ok_at, -1);
        chk("midreset_tail_err", err_at, -1);
        chk("midreset_tail_outs", outs, 16'h0);
        send_frame(25'h07F7FA5, 24, ok_at, err_at, acc);
        chk("post_reset_ok_at", ok_at, 3);
        chk("post_reset_outs", outs, 16'h7F7F);
        chk("post_reset_link", lnk, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
